result_checker: RTL

Synthesizable end-of-test monitor for the 6502 core regression suites. It snoops the CPU write bus and captures writes to up to N_CHK result addresses, comparing each against an expected byte. The test ends when the program parks in a `JMP *` trap or a cycle budget runs out. Pass, fail and timeout are reported as registered flags. It replaces fixed-delay single-address checks with a multi-channel, trap-terminated checker usable by every suite.

---
 rtl/result_checker.sv | 102 ++++++++++
 1 files changed

// File: rtl/result_checker.sv
// result_checker: snoops CPU writes into per-channel captures and grades them when the
// program parks in a JMP * trap or the RUN cycle budget expires.
module result_checker #(
  parameter int N_CHK = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = 16'd4000,
  parameter int MODE = 0,
  parameter int TRAP_EN = 1
) (
  input  logic                    ph2,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    we,
  input  logic                    sync,
  input  logic [N_CHK*ADDR_W-1:0] chk_addr,
  input  logic [N_CHK*DATA_W-1:0] chk_data,
  input  logic [N_CHK-1:0]        chk_en,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [N_CHK-1:0]        written,
  output logic [N_CHK-1:0]        mismatch,
  output logic [CNT_W-1:0]        cycles
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [N_CHK*ADDR_W-1:0] lat_addr;
  logic [N_CHK*DATA_W-1:0] lat_data, cap, cap_nx;
  logic [N_CHK-1:0] lat_en, hit, neq, wr_nx, mis_nx;
  logic [ADDR_W-1:0] trap_addr;
  logic trap_v, trap, to_end, pass_nx;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    cap_nx = cap;
    hit = '0;
    neq = '0;
    for (int i = 0; i < N_CHK; i++) begin
      hit[i] = lat_en[i] && we && addr == lat_addr[i*ADDR_W +: ADDR_W] && (MODE == 0 || !written[i]);
      if (hit[i]) cap_nx[i*DATA_W +: DATA_W] = wdata;
      neq[i] = cap_nx[i*DATA_W +: DATA_W] != lat_data[i*DATA_W +: DATA_W];
    end
  end
  // grading includes the write sampled on the ending edge
  assign wr_nx = written | hit;
  assign mis_nx = lat_en & (~wr_nx | neq);
  assign trap = TRAP_EN != 0 && sync && trap_v && addr == trap_addr;
  assign to_end = cycles == TIMEOUT - 1'b1;
  assign pass_nx = mis_nx == '0 && (trap || !to_end);
  always_ff @(posedge ph2) begin
    if (reset) begin
      state <= IDLE;
      lat_addr <= '0;
      lat_data <= '0;
      lat_en <= '0;
      cap <= '0;
      written <= '0;
      mismatch <= '0;
      cycles <= '0;
      trap_addr <= '0;
      trap_v <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      timeout <= 1'b0;
    end else if (start) begin
      state <= RUN;
      lat_addr <= chk_addr;
      lat_data <= chk_data;
      lat_en <= chk_en;
      cap <= '0;
      written <= '0;
      mismatch <= '0;
      cycles <= '0;
      trap_addr <= '0;
      trap_v <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      timeout <= 1'b0;
    end else if (state == RUN) begin
      cycles <= cycles + 1'b1;
      cap <= cap_nx;
      written <= wr_nx;
      if (sync) begin
        trap_addr <= addr;
        trap_v <= 1'b1;
      end
      if (trap || to_end) begin
        state <= DONE;
        mismatch <= mis_nx;
        pass <= pass_nx;
        fail <= !pass_nx;
        timeout <= to_end && !trap;
      end
    end
  end
endmodule
